game_frame_renderer: RTL and testbench

//  Display-side consumer of the game-control state bus: VGA 640x480 timing plus sprite compositor.

---
 rtl/game_frame_renderer_pkg.sv | 107 ++++++++++
 rtl/game_frame_renderer_vga_timing.sv | 58 +++++
 rtl/game_frame_renderer.sv | 244 ++++++++++++++++++++++++
 tb/tb_game_frame_renderer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_frame_renderer_pkg.sv
// Shared definitions for the game frame renderer: default VGA 640x480 timing,
// sprite/bullet sizes, HUD geometry, game-state encodings, the rgb_t pixel type
// with its colour constants, and the small signed hit-test helpers.
package game_frame_renderer_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int SPRITE_W_DEF = 32;
    localparam int BULLET_W_DEF = 8;

    // HP bar geometry: 3 segments of 16x8 with 4-px gaps, 8 px in from the edges.
    localparam int HP_MAX       = 3;
    localparam int HP_SEG_W     = 16;
    localparam int HP_SEG_H     = 8;
    localparam int HP_SEG_GAP   = 4;
    localparam int HUD_Y        = 8;
    localparam int HUD_MARGIN   = 8;
    localparam int HUD_SPAN     = HP_MAX * HP_SEG_W + (HP_MAX - 1) * HP_SEG_GAP;

    typedef enum logic [1:0] {
        ST_START = 2'b00,
        ST_PLAY  = 2'b01,
        ST_WIN   = 2'b10,
        ST_LOSE  = 2'b11
    } game_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t C_WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t C_RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam rgb_t C_GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam rgb_t C_BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_t C_CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam rgb_t C_YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam rgb_t C_MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    localparam rgb_t C_ORANGE  = '{r: 8'hFF, g: 8'hA5, b: 8'h00};

    // Per-frame copy of the game-control bus (hit points live in the top, HUD builds only).
    typedef struct packed {
        game_state_e state;
        logic [10:0] player_x;
        logic [10:0] enemy_x;
        logic [10:0] goodbullet_x;
        logic [10:0] badbullet_x;
        logic [9:0]  player_y;
        logic [9:0]  enemy_y;
        logic [9:0]  goodbullet_y;
        logic [9:0]  badbullet_y;
        logic        player_shield;
        logic        enemy_shield;
        logic        player_squat;
        logic        enemy_squat;
        logic        goodbullet_is_e;
        logic        badbullet_is_e;
    } snap_t;

    // All-zero is the START screen with every object at (0,0) and no flags set.
    localparam snap_t SNAP_RESET = '0;

    typedef struct packed {
        logic hud_lit;
        logic hud_lost;
        logic good_bullet;
        logic bad_bullet;
        logic player;
        logic player_ring;
        logic enemy;
        logic enemy_ring;
    } hits_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame_start;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame_start: 1'b0};

    function automatic logic signed [11:0] sext11(input logic [10:0] a);
        return {a[10], a};
    endfunction

    function automatic logic signed [11:0] sext10(input logic [9:0] a);
        return {{2{a[9]}}, a};
    endfunction

    // p in [lo, lo+len), all signed 12-bit so negative origins clip naturally.
    function automatic logic in_span(input logic signed [11:0] p,
                                     input logic signed [11:0] lo,
                                     input logic signed [11:0] len);
        return (p >= lo) && (p < lo + len);
    endfunction

endpackage

// File: rtl/game_frame_renderer_vga_timing.sv
// VGA timing generator (pipeline stage 1) for the game frame renderer.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   h, v                current pixel/line counters (h 0..H_TOTAL-1, v 0..V_TOTAL-1)
//   hsync, vsync        active-low syncs decoded from the counters (unregistered)
//   active              1 inside the visible area
//   frame_start         1 at counter (0, V_ACTIVE): the per-frame snapshot point
module game_frame_renderer_vga_timing
    import game_frame_renderer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h,
    output logic [9:0] v,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign hsync       = !((h >= HS_FIRST) && (h < HS_END));
    assign vsync       = !((v >= VS_FIRST) && (v < VS_END));
    assign active      = (h < H_ACT) && (v < V_ACT);
    assign frame_start = (h == 10'd0) && (v == V_ACT);

endmodule

// File: rtl/game_frame_renderer.sv
// Game frame renderer: VGA timing plus sprite compositor between game control
// and the VGA DAC. Inputs are snapshotted once per frame at counter (0, V_ACTIVE)
// so a frame never tears. Pipeline: counter -> hit-test -> colour; every output
// (syncs, blank, RGB, frame_start) shows counter (h,v) two cycles later.
// Ports:
//   clk, rst_n                       25 MHz pixel clock, async active-low reset
//   i_state                          00 START, 01 PLAY, 10 WIN, 11 LOSE
//   i_*_x (11b signed), i_*_y (10b signed)  top-left of player/enemy/bullets
//   i_player_hp, i_enemy_hp          hit points 0..3 (HUD builds only)
//   i_*_shield, i_*_squat            sprite modifiers
//   i_goodbullet_isE, i_badbullet_isE  bullet exists
//   o_hsync, o_vsync                 active-low syncs
//   o_blank_n                        1 = active video
//   o_r, o_g, o_b                    pixel colour (0 while blanked)
//   o_frame_start                    1-cycle pulse for the snapshot point
// Configuration: define HUD_HP_BAR_EN to draw the HP bars on the PLAY screen.
module game_frame_renderer
    import game_frame_renderer_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int BULLET_W = BULLET_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  i_state,
    input  logic [10:0] i_player_x,
    input  logic [10:0] i_enemy_x,
    input  logic [10:0] i_goodbullet_x,
    input  logic [10:0] i_badbullet_x,
    input  logic [9:0]  i_player_y,
    input  logic [9:0]  i_enemy_y,
    input  logic [9:0]  i_goodbullet_y,
    input  logic [9:0]  i_badbullet_y,
    input  logic [1:0]  i_player_hp,
    input  logic [1:0]  i_enemy_hp,
    input  logic        i_player_shield,
    input  logic        i_enemy_shield,
    input  logic        i_player_squat,
    input  logic        i_enemy_squat,
    input  logic        i_goodbullet_isE,
    input  logic        i_badbullet_isE,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_blank_n,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic        o_frame_start
);

    localparam logic signed [11:0] SPR_W  = 12'(SPRITE_W);
    localparam logic signed [11:0] SPR_H2 = 12'(SPRITE_W / 2);
    localparam logic signed [11:0] BUL_W  = 12'(BULLET_W);

    // ---------------- stage 1: counters and sync decode ----------------
    logic [9:0] h, v;
    logic       t_hsync, t_vsync, t_active, frame_start;
    sync_t      sync_d, sync_q;

    game_frame_renderer_vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .h           (h),
        .v           (v),
        .hsync       (t_hsync),
        .vsync       (t_vsync),
        .active      (t_active),
        .frame_start (frame_start)
    );

    assign sync_d = '{hsync: t_hsync, vsync: t_vsync, active: t_active, frame_start: frame_start};

    // ---------------- per-frame snapshot ----------------
    snap_t snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= SNAP_RESET;
        end else if (frame_start) begin
            snap <= '{state:           game_state_e'(i_state),
                      player_x:        i_player_x,
                      enemy_x:         i_enemy_x,
                      goodbullet_x:    i_goodbullet_x,
                      badbullet_x:     i_badbullet_x,
                      player_y:        i_player_y,
                      enemy_y:         i_enemy_y,
                      goodbullet_y:    i_goodbullet_y,
                      badbullet_y:     i_badbullet_y,
                      player_shield:   i_player_shield,
                      enemy_shield:    i_enemy_shield,
                      player_squat:    i_player_squat,
                      enemy_squat:     i_enemy_squat,
                      goodbullet_is_e: i_goodbullet_isE,
                      badbullet_is_e:  i_badbullet_isE};
        end
    end

    // ---------------- stage 2: hit tests ----------------
    logic signed [11:0] px, py;
    logic signed [11:0] player_top, player_hgt, enemy_top, enemy_hgt;
    logic signed [11:0] player_x, enemy_x;
    logic               player_body, player_inner, enemy_body, enemy_inner;
    logic               hud_lit, hud_lost;
    hits_t              hits_d, hits_q;

    assign px = signed'({2'b00, h});
    assign py = signed'({2'b00, v});

    // Squatting halves the box and keeps its bottom edge where it was.
    assign player_x   = sext11(snap.player_x);
    assign player_top = snap.player_squat ? sext10(snap.player_y) + SPR_H2 : sext10(snap.player_y);
    assign player_hgt = snap.player_squat ? SPR_H2 : SPR_W;
    assign enemy_x    = sext11(snap.enemy_x);
    assign enemy_top  = snap.enemy_squat ? sext10(snap.enemy_y) + SPR_H2 : sext10(snap.enemy_y);
    assign enemy_hgt  = snap.enemy_squat ? SPR_H2 : SPR_W;

    assign player_body  = in_span(px, player_x, SPR_W) && in_span(py, player_top, player_hgt);
    assign enemy_body   = in_span(px, enemy_x, SPR_W) && in_span(py, enemy_top, enemy_hgt);
    // The shield ring is whatever of the box lies outside a box shrunk by 2 px per side.
    assign player_inner = in_span(px, player_x + 12'sd2, SPR_W - 12'sd4)
                       && in_span(py, player_top + 12'sd2, player_hgt - 12'sd4);
    assign enemy_inner  = in_span(px, enemy_x + 12'sd2, SPR_W - 12'sd4)
                       && in_span(py, enemy_top + 12'sd2, enemy_hgt - 12'sd4);

`ifdef HUD_HP_BAR_EN
    localparam int HUD_ENEMY_X = H_ACTIVE - HUD_MARGIN - HUD_SPAN;

    logic [1:0] player_hp, enemy_hp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            player_hp <= 2'd3;
            enemy_hp  <= 2'd3;
        end else if (frame_start) begin
            player_hp <= i_player_hp;
            enemy_hp  <= i_enemy_hp;
        end
    end

    // Segment i (from the left) is lit while i < hp, otherwise drawn as lost.
    always_comb begin
        hud_lit  = 1'b0;
        hud_lost = 1'b0;
        for (int i = 0; i < HP_MAX; i++) begin
            if (in_span(py, 12'(HUD_Y), 12'(HP_SEG_H))) begin
                if (in_span(px, 12'(HUD_MARGIN + i * (HP_SEG_W + HP_SEG_GAP)), 12'(HP_SEG_W))) begin
                    if (2'(i) < player_hp) hud_lit = 1'b1;
                    else                   hud_lost = 1'b1;
                end
                if (in_span(px, 12'(HUD_ENEMY_X + i * (HP_SEG_W + HP_SEG_GAP)), 12'(HP_SEG_W))) begin
                    if (2'(i) < enemy_hp) hud_lit = 1'b1;
                    else                  hud_lost = 1'b1;
                end
            end
        end
    end
`else
    logic unused_hp;
    assign unused_hp = ^{i_player_hp, i_enemy_hp};
    assign hud_lit   = 1'b0;
    assign hud_lost  = 1'b0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        hits_d             = '0;
        hits_d.hud_lit     = hud_lit;
        hits_d.hud_lost    = hud_lost;
        hits_d.good_bullet = snap.goodbullet_is_e
                          && in_span(px, sext11(snap.goodbullet_x), BUL_W)
                          && in_span(py, sext10(snap.goodbullet_y), BUL_W);
        hits_d.bad_bullet  = snap.badbullet_is_e
                          && in_span(px, sext11(snap.badbullet_x), BUL_W)
                          && in_span(py, sext10(snap.badbullet_y), BUL_W);
        hits_d.player      = player_body;
        hits_d.player_ring = player_body && !player_inner && snap.player_shield;
        hits_d.enemy       = enemy_body;
        hits_d.enemy_ring  = enemy_body && !enemy_inner && snap.enemy_shield;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q <= '0;
            sync_q <= SYNC_IDLE;
        end else begin
            hits_q <= hits_d;
            sync_q <= sync_d;
        end
    end

    // ---------------- stage 3: colour mux and output registers ----------------
    rgb_t pix_d;

    always_comb begin
        pix_d = C_BLACK;
        case (snap.state)
            ST_START: pix_d = C_BLUE;
            ST_WIN:   pix_d = C_GREEN;
            ST_LOSE:  pix_d = C_RED;
            default: begin
                if      (hits_q.hud_lit)     pix_d = C_GREEN;
                else if (hits_q.hud_lost)    pix_d = C_RED;
                else if (hits_q.good_bullet) pix_d = C_YELLOW;
                else if (hits_q.bad_bullet)  pix_d = C_MAGENTA;
                else if (hits_q.player)      pix_d = hits_q.player_ring ? C_CYAN : C_WHITE;
                else if (hits_q.enemy)       pix_d = hits_q.enemy_ring ? C_CYAN : C_ORANGE;
            end
        endcase
        if (!sync_q.active) pix_d = C_BLACK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_hsync       <= 1'b1;
            o_vsync       <= 1'b1;
            o_blank_n     <= 1'b0;
            o_frame_start <= 1'b0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
        end else begin
            o_hsync       <= sync_q.hsync;
            o_vsync       <= sync_q.vsync;
            o_blank_n     <= sync_q.active;
            o_frame_start <= sync_q.frame_start;
            o_r           <= pix_d.r;
            o_g           <= pix_d.g;
            o_b           <= pix_d.b;
        end
    end

endmodule

// File: tb/tb_game_frame_renderer.sv
// Directed bench for game_frame_renderer. Uses a shrunken raster
// (160x62 total, 144x56 visible) so eight frames fit in a short run; sprite
// coordinates keep their x values and are moved up in y to fit the visible area.
// A local cycle counter gives the DUT counter position: counter (h,v) of
// frame f is held in cycle f*FRAME + v*HT + h, and its outputs appear 2 cycles later.
module tb_game_frame_renderer;

    localparam int HA = 144, HF = 4, HS = 8, HB = 4;
    localparam int VA = 56,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 160
    localparam int VT = VA + VF + VS + VB;   // 62
    localparam int FRAME = HT * VT;          // 9920

    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;
    localparam logic [23:0] ORANGE  = 24'hFFA500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  state;
    logic [10:0] player_x, enemy_x, goodbullet_x, badbullet_x;
    logic [9:0]  player_y, enemy_y, goodbullet_y, badbullet_y;
    logic [1:0]  player_hp, enemy_hp;
    logic        player_shield, enemy_shield, player_squat, enemy_squat;
    logic        goodbullet_is_e, badbullet_is_e;
    logic        hsync, vsync, blank_n, frame_start;
    logic [7:0]  r, g, b;

    int checks = 0;
    int errors = 0;
    int cyc;
    int hs_low = 0;
    int vs_low = 0;

    game_frame_renderer #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SPRITE_W (32), .BULLET_W (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_state          (state),
        .i_player_x       (player_x),
        .i_enemy_x        (enemy_x),
        .i_goodbullet_x   (goodbullet_x),
        .i_badbullet_x    (badbullet_x),
        .i_player_y       (player_y),
        .i_enemy_y        (enemy_y),
        .i_goodbullet_y   (goodbullet_y),
        .i_badbullet_y    (badbullet_y),
        .i_player_hp      (player_hp),
        .i_enemy_hp       (enemy_hp),
        .i_player_shield  (player_shield),
        .i_enemy_shield   (enemy_shield),
        .i_player_squat   (player_squat),
        .i_enemy_squat    (enemy_squat),
        .i_goodbullet_isE (goodbullet_is_e),
        .i_badbullet_isE  (badbullet_is_e),
        .o_hsync          (hsync),
        .o_vsync          (vsync),
        .o_blank_n        (blank_n),
        .o_r              (r),
        .o_g              (g),
        .o_b              (b),
        .o_frame_start    (frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Sync-low totals over exactly one frame of outputs (counters 0..FRAME-1).
    always @(negedge clk) begin
        if (rst_n && cyc >= 2 && cyc < 2 + FRAME) begin
            if (!hsync) hs_low <= hs_low + 1;
            if (!vsync) vs_low <= vs_low + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the cycle where outputs show counter (h,v) of frame f.
    task automatic wait_ctr(input int f, input int h, input int v);
        int t;
        t = f * FRAME + v * HT + h + 2;
        check("order", 32'(cyc <= t), 32'd1);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input string tag, input int f, input int h, input int v,
                       input logic [23:0] exp, input logic exp_active);
        wait_ctr(f, h, v);
        check(tag, {7'd0, blank_n, r, g, b}, {7'd0, exp_active, exp});
    endtask

    initial begin
        state = 2'b00;
        player_x = '0; enemy_x = '0; goodbullet_x = '0; badbullet_x = '0;
        player_y = '0; enemy_y = '0; goodbullet_y = '0; badbullet_y = '0;
        player_hp = 2'd3; enemy_hp = 2'd3;
        player_shield = 0; enemy_shield = 0; player_squat = 0; enemy_squat = 0;
        goodbullet_is_e = 0; badbullet_is_e = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {25'd0, hsync, vsync, blank_n, frame_start, 3'd0},
              {25'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0});
        check("reset_rgb", {8'd0, r, g, b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Frame 0: reset snapshot gives START.
        wait_ctr(0, 147, 0); check("hsync_pre", 32'(hsync), 32'd1);
        wait_ctr(0, 148, 0); check("hsync_first", 32'(hsync), 32'd0);
        wait_ctr(0, 155, 0); check("hsync_last", 32'(hsync), 32'd0);
        wait_ctr(0, 156, 0); check("hsync_post", 32'(hsync), 32'd1);
        pix("start_fill", 0, 10, 5, BLUE, 1'b1);
        pix("start_hblank", 0, 150, 5, BLACK, 1'b0);
        state = 2'b10;  // WIN mid-frame: must not appear before the snapshot
        pix("win_no_tear", 0, 10, 30, BLUE, 1'b1);
        pix("start_last_px", 0, 143, 55, BLUE, 1'b1);
        wait_ctr(0, 159, 55); check("fs_before", 32'(frame_start), 32'd0);
        wait_ctr(0, 0, 56);   check("fs_pulse", 32'(frame_start), 32'd1);
        check("vblank_rgb", {7'd0, blank_n, r, g, b}, 32'd0);
        wait_ctr(0, 1, 56);   check("fs_after", 32'(frame_start), 32'd0);
        wait_ctr(0, 159, 57); check("vsync_pre", 32'(vsync), 32'd1);
        wait_ctr(0, 0, 58);   check("vsync_first", 32'(vsync), 32'd0);
        wait_ctr(0, 0, 60);   check("vsync_post", 32'(vsync), 32'd1);

        // Frame 1: WIN.
        pix("win_fill", 1, 0, 0, GREEN, 1'b1);
        check("hsync_low_cycles", 32'(hs_low), 32'(VT * HS));
        check("vsync_low_cycles", 32'(vs_low), 32'(VS * HT));
        state = 2'b01;
        player_x = 11'd100; player_y = 10'd20;
        player_hp = 2'd2; enemy_hp = 2'd3;
        pix("play_no_tear", 1, 100, 20, GREEN, 1'b1);

        // Frame 2: PLAY, player box x 100..131, y 20..51.
`ifdef HUD_HP_BAR_EN
        pix("hud_p_lit", 2, 8, 8, GREEN, 1'b1);
        pix("hud_p_lost", 2, 48, 8, RED, 1'b1);
        pix("hud_e_lit", 2, 80, 8, GREEN, 1'b1);
`endif
        pix("left_of_player", 2, 99, 20, BLACK, 1'b1);
        pix("player_corner", 2, 100, 20, WHITE, 1'b1);
        pix("player_right_in", 2, 131, 20, WHITE, 1'b1);
        pix("player_right_out", 2, 132, 20, BLACK, 1'b1);
        pix("player_bottom_in", 2, 100, 51, WHITE, 1'b1);
        pix("player_bottom_out", 2, 100, 52, BLACK, 1'b1);
        player_squat = 1'b1;

        // Frame 3: squat, box y 36..51.
        pix("squat_old_top", 3, 100, 20, BLACK, 1'b1);
        pix("squat_above", 3, 100, 35, BLACK, 1'b1);
        pix("squat_top", 3, 100, 36, WHITE, 1'b1);
        pix("squat_bottom", 3, 100, 51, WHITE, 1'b1);
        pix("squat_below", 3, 100, 52, BLACK, 1'b1);
        player_shield = 1'b1;

        // Frame 4: squat + shield, inner box x 102..129, y 38..49.
        pix("ring_top", 4, 110, 37, CYAN, 1'b1);
        pix("ring_left", 4, 101, 40, CYAN, 1'b1);
        pix("ring_inside", 4, 110, 40, WHITE, 1'b1);
        pix("ring_right", 4, 130, 40, CYAN, 1'b1);
        player_squat = 1'b0; player_shield = 1'b0;
        goodbullet_x = 11'd104; goodbullet_y = 10'd24; goodbullet_is_e = 1'b1;
        badbullet_x  = 11'd108; badbullet_y  = 10'd28; badbullet_is_e  = 1'b1;
        enemy_x = 11'd20; enemy_y = 10'd30;

        // Frame 5: good bullet 104..111/24..31, bad bullet 108..115/28..35, enemy 20..51/30..
        pix("good_over_player", 5, 104, 24, YELLOW, 1'b1);
        pix("enemy_corner", 5, 20, 30, ORANGE, 1'b1);
        pix("enemy_right_out", 5, 52, 30, BLACK, 1'b1);
        pix("good_over_bad", 5, 110, 30, YELLOW, 1'b1);
        pix("bad_over_player", 5, 114, 34, MAGENTA, 1'b1);
        pix("player_clear", 5, 120, 40, WHITE, 1'b1);
        goodbullet_is_e = 1'b0; badbullet_is_e = 1'b0;

        // Frame 6: bullets absent.
        pix("good_absent", 6, 104, 24, WHITE, 1'b1);
        pix("bad_absent", 6, 114, 34, WHITE, 1'b1);
        player_x = 11'h7F0;  // -16

        // Frame 7: player box x -16..15 clipped at the left edge.
        pix("clip_col0", 7, 0, 20, WHITE, 1'b1);
        pix("clip_col15", 7, 15, 20, WHITE, 1'b1);
        pix("clip_col16", 7, 16, 20, BLACK, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
